// File: rtl/bus_demo_pkg.sv
// Shared types for the serial-bus demo operator controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_demo_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int SW_WIDTH       = 18;

   typedef enum logic [1:0] {
      NO_SLAVE = 2'd0,
      SLAVE_1  = 2'd1,
      SLAVE_2  = 2'd2,
      SLAVE_3  = 2'd3
   } slave_t;

   typedef enum logic {
      MASTER_0 = 1'b0,
      MASTER_1 = 1'b1
   } master_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } operation_t;

   // Encoding is what the HEX display shows.
   typedef enum logic [3:0] {
      ST_SLV_SEL  = 4'd0,
      ST_RW_SEL   = 4'd1,
      ST_EXTW_SEL = 4'd2,
      ST_EXTW0    = 4'd3,
      ST_EXTW1    = 4'd4,
      ST_SA0      = 4'd5,
      ST_SA1      = 4'd6,
      ST_EA0      = 4'd7,
      ST_EA1      = 4'd8,
      ST_CFG      = 4'd9,
      ST_READY    = 4'd10,
      ST_COMM     = 4'd11,
      ST_DONE     = 4'd12
   } state_t;

endpackage

// File: rtl/key_press_det.sv
// Push-button press detector: one-cycle pulse on each 1->0 transition of an active-low key.
// Latency: pulse 1 cycle after the key is sampled low (3 cycles with KEY_SYNC_EN defined).
// Backpressure: none; a held key produces exactly one pulse.
// Ports: i_clk, i_rst (sync, active-high), i_key_n (raw active-low key), o_press (pulse).
// Build option: KEY_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module key_press_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);

   logic r_key;
   logic r_key_d;

`ifdef KEY_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= 2'b11;
         r_key   <= 1'b1;
         r_key_d <= 1'b1;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_key   <= r_sync[1];
         r_key_d <= r_key;
      end
   end
`else
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_key   <= 1'b1;
         r_key_d <= 1'b1;
      end else begin
         r_key   <= i_key_n;
         r_key_d <= r_key;
      end
   end
`endif

   // Released level is 1, so reset never fakes a press.
   assign o_press = r_key_d & ~r_key;

endmodule

// File: rtl/bus_demo_ctrl.sv
// Operator sequencing FSM: turns switches and key presses into master config, then runs the bus demo.
// Latency: actions register 1 cycle after a detected key press; all outputs are registered.
// Backpressure: none; waits on i_cfg_done / i_com_done levels, keys are single-shot.
// Ports: i_clk, i_rst, i_key_*_n (buttons), i_sw (switches), o_m_* (per-master config),
//        o_ext_wr_* (master memory write), o_cfg_start/i_cfg_done, o_com_start/i_com_done,
//        o_rd_addr, o_ext_com_en, o_com_ready, o_com_all_done, o_state_code.
// Build option: KEY_SYNC_EN (see key_press_det) synchronizes the keys.
module bus_demo_ctrl
   import bus_demo_pkg::*;
#(
   parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH             = DEF_ADDR_WIDTH,
   parameter int MAX_MASTER_WRITE_DEPTH = 16,
   parameter int FIRST_START_MASTER     = 0,
   parameter int COM_START_DELAY        = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_key_state_n,
   input  logic                       i_key_next_addr_n,
   input  logic                       i_key_ext_com_n,
   input  logic [SW_WIDTH-1:0]        i_sw,
   output logic [1:0][1:0]            o_m_slave_sel,
   output logic [1:0]                 o_m_rw,
   output logic [1:0][ADDR_WIDTH-1:0] o_m_start_addr,
   output logic [1:0][ADDR_WIDTH-1:0] o_m_end_addr,
   output logic [1:0]                 o_ext_wr_en,
   output logic [ADDR_WIDTH-1:0]      o_ext_wr_addr,
   output logic [DATA_WIDTH-1:0]      o_ext_wr_data,
   output logic                       o_cfg_start,
   input  logic                       i_cfg_done,
   output logic [1:0]                 o_com_start,
   input  logic [1:0]                 i_com_done,
   output logic [ADDR_WIDTH-1:0]      o_rd_addr,
   output logic                       o_ext_com_en,
   output logic                       o_com_ready,
   output logic                       o_com_all_done,
   output logic [3:0]                 o_state_code
);

   localparam int   CNT_W     = (MAX_MASTER_WRITE_DEPTH > 1) ? $clog2(MAX_MASTER_WRITE_DEPTH) : 1;
   localparam int   DLY_W     = (COM_START_DELAY > 0) ? $clog2(COM_START_DELAY + 1) : 1;
   localparam logic FIRST_IDX = (FIRST_START_MASTER != 0);
   localparam logic OTHER_IDX = !FIRST_IDX;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MASTER_WRITE_DEPTH - 1);

   logic w_st;
   logic w_na;
   logic w_ext;
   logic [1:0] w_active;
   logic w_extw_m;
   logic [DATA_WIDTH-1:0] w_sw_data;
   logic w_unused_sw;

   state_t                      r_state;
   logic [1:0][1:0]             r_slave_sel;
   logic [1:0]                  r_rw;
   logic [1:0]                  r_extw_en;
   logic [CNT_W-1:0]            r_cnt;
   logic [1:0][ADDR_WIDTH-1:0]  r_start_addr;
   logic [1:0][ADDR_WIDTH-1:0]  r_end_addr;
   logic [1:0]                  r_ext_wr_en;
   logic [ADDR_WIDTH-1:0]       r_ext_wr_addr;
   logic [DATA_WIDTH-1:0]       r_ext_wr_data;
   logic                        r_cfg_start;
   logic [1:0]                  r_com_start;
   logic                        r_dly_pend;
   logic [DLY_W-1:0]            r_dly_cnt;
   logic [ADDR_WIDTH-1:0]       r_rd_addr;
   logic                        r_ext_com_en;
   logic                        r_com_ready;
   logic                        r_com_all_done;

   key_press_det u_key_state (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key_state_n),
      .o_press (w_st)
   );

   key_press_det u_key_next_addr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key_next_addr_n),
      .o_press (w_na)
   );

   key_press_det u_key_ext_com (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key_ext_com_n),
      .o_press (w_ext)
   );

   assign w_active[0] = (r_slave_sel[0] != NO_SLAVE);
   assign w_active[1] = (r_slave_sel[1] != NO_SLAVE);
   assign w_extw_m    = (r_state == ST_EXTW1);
   assign w_sw_data   = DATA_WIDTH'(i_sw[15:0]);
   assign w_unused_sw = ^i_sw[SW_WIDTH-1:16];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= ST_SLV_SEL;
         r_slave_sel    <= '0;
         r_rw           <= '0;
         r_extw_en      <= '0;
         r_cnt          <= '0;
         r_start_addr   <= '0;
         r_end_addr     <= '0;
         r_ext_wr_en    <= '0;
         r_ext_wr_addr  <= '0;
         r_ext_wr_data  <= '0;
         r_cfg_start    <= 1'b0;
         r_com_start    <= '0;
         r_dly_pend     <= 1'b0;
         r_dly_cnt      <= '0;
         r_rd_addr      <= '0;
         r_ext_com_en   <= 1'b0;
         r_com_ready    <= 1'b0;
         r_com_all_done <= 1'b0;
      end else begin
         // Strobes are single-cycle by default.
         r_ext_wr_en <= '0;
         r_cfg_start <= 1'b0;
         r_com_start <= '0;

         if (w_ext) r_ext_com_en <= ~r_ext_com_en;

         case (r_state)
            ST_SLV_SEL: if (w_st) begin
               r_slave_sel[0] <= i_sw[1:0];
               r_slave_sel[1] <= i_sw[3:2];
               if (i_sw[3:0] == 4'd0) begin
                  r_state        <= ST_DONE;
                  r_com_all_done <= 1'b1;
               end else begin
                  r_state <= ST_RW_SEL;
               end
            end
            ST_RW_SEL: if (w_st) begin
               r_rw    <= i_sw[1:0];
               r_state <= ST_EXTW_SEL;
            end
            ST_EXTW_SEL: if (w_st) begin
               r_extw_en <= i_sw[1:0];
               r_cnt     <= '0;
               if (i_sw[0])      r_state <= ST_EXTW0;
               else if (i_sw[1]) r_state <= ST_EXTW1;
               else              r_state <= ST_SA0;
            end
            ST_EXTW0, ST_EXTW1: begin
               // A state press also writes; it takes priority over a same-cycle next-address press.
               if (w_st || w_na) begin
                  r_ext_wr_en[w_extw_m] <= 1'b1;
                  r_ext_wr_addr         <= ADDR_WIDTH'(r_cnt);
                  r_ext_wr_data         <= w_sw_data;
               end
               if (w_st) begin
                  r_cnt   <= '0;
                  r_state <= (!w_extw_m && r_extw_en[1]) ? ST_EXTW1 : ST_SA0;
               end else if (w_na && (r_cnt != CNT_MAX)) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SA0: if (w_st) begin
               r_start_addr[0] <= i_sw[ADDR_WIDTH-1:0];
               r_state         <= ST_SA1;
            end
            ST_SA1: if (w_st) begin
               r_start_addr[1] <= i_sw[ADDR_WIDTH-1:0];
               r_state         <= ST_EA0;
            end
            ST_EA0: if (w_st) begin
               r_end_addr[0] <= i_sw[ADDR_WIDTH-1:0];
               r_state       <= ST_EA1;
            end
            ST_EA1: if (w_st) begin
               r_end_addr[1] <= i_sw[ADDR_WIDTH-1:0];
               r_cfg_start   <= 1'b1;
               r_state       <= ST_CFG;
            end
            ST_CFG: if (i_cfg_done) begin
               r_com_ready <= 1'b1;
               r_state     <= ST_READY;
            end
            ST_READY: if (w_st) begin
               r_com_ready              <= 1'b0;
               r_state                  <= ST_COMM;
               r_com_start[FIRST_IDX]   <= w_active[FIRST_IDX];
               if (COM_START_DELAY == 0) begin
                  r_com_start[OTHER_IDX] <= w_active[OTHER_IDX];
               end else begin
                  r_dly_pend <= w_active[OTHER_IDX];
                  r_dly_cnt  <= DLY_W'(COM_START_DELAY);
               end
            end
            ST_COMM: begin
               if (r_dly_pend) begin
                  if (r_dly_cnt == DLY_W'(1)) begin
                     r_com_start[OTHER_IDX] <= 1'b1;
                     r_dly_pend             <= 1'b0;
                  end else begin
                     r_dly_cnt <= r_dly_cnt - 1'b1;
                  end
               // Idle masters count as done; ignore done levels until every start has gone out.
               end else if ((r_com_start == 2'b00) && (&(i_com_done | ~w_active))) begin
                  r_state        <= ST_DONE;
                  r_com_all_done <= 1'b1;
               end
            end
            ST_DONE: if (w_na) begin
               r_rd_addr <= i_sw[ADDR_WIDTH-1:0];
            end
            default: r_state <= ST_SLV_SEL;
         endcase
      end
   end

   assign o_m_slave_sel  = r_slave_sel;
   assign o_m_rw         = r_rw;
   assign o_m_start_addr = r_start_addr;
   assign o_m_end_addr   = r_end_addr;
   assign o_ext_wr_en    = r_ext_wr_en;
   assign o_ext_wr_addr  = r_ext_wr_addr;
   assign o_ext_wr_data  = r_ext_wr_data;
   assign o_cfg_start    = r_cfg_start;
   assign o_com_start    = r_com_start;
   assign o_rd_addr      = r_rd_addr;
   assign o_ext_com_en   = r_ext_com_en;
   assign o_com_ready    = r_com_ready;
   assign o_com_all_done = r_com_all_done;
   assign o_state_code   = r_state;

endmodule

// File: tb/tb_bus_demo_ctrl.sv
module tb_bus_demo_ctrl;
   import bus_demo_pkg::*;

   localparam logic [2:0] K_ST  = 3'b001;
   localparam logic [2:0] K_NA  = 3'b010;
   localparam logic [2:0] K_EXT = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  keys_n;
   logic [17:0] sw;
   logic        cfg_done;
   logic [1:0]  com_done;

   logic [1:0][1:0]  d0_slave_sel, d1_slave_sel;
   logic [1:0]       d0_rw, d1_rw;
   logic [1:0][11:0] d0_sa, d1_sa, d0_ea, d1_ea;
   logic [1:0]       d0_wr_en, d1_wr_en;
   logic [11:0]      d0_wr_addr, d1_wr_addr;
   logic [15:0]      d0_wr_data, d1_wr_data;
   logic             d0_cfg_start, d1_cfg_start;
   logic [1:0]       d0_com_start, d1_com_start;
   logic [11:0]      d0_rd_addr, d1_rd_addr;
   logic             d0_ext_com, d1_ext_com;
   logic             d0_ready, d1_ready;
   logic             d0_all_done, d1_all_done;
   logic [3:0]       d0_state, d1_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int cfg_cnt;
   int cs0_cnt, cs1_cnt;
   int cs0_cyc[2];
   int cs1_cyc[2];
   logic [29:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_demo_ctrl u_dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_key_state_n(keys_n[0]), .i_key_next_addr_n(keys_n[1]), .i_key_ext_com_n(keys_n[2]),
      .i_sw(sw), .o_m_slave_sel(d0_slave_sel), .o_m_rw(d0_rw),
      .o_m_start_addr(d0_sa), .o_m_end_addr(d0_ea),
      .o_ext_wr_en(d0_wr_en), .o_ext_wr_addr(d0_wr_addr), .o_ext_wr_data(d0_wr_data),
      .o_cfg_start(d0_cfg_start), .i_cfg_done(cfg_done),
      .o_com_start(d0_com_start), .i_com_done(com_done),
      .o_rd_addr(d0_rd_addr), .o_ext_com_en(d0_ext_com), .o_com_ready(d0_ready),
      .o_com_all_done(d0_all_done), .o_state_code(d0_state)
   );

   bus_demo_ctrl #(.FIRST_START_MASTER(1), .COM_START_DELAY(5)) u_dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_key_state_n(keys_n[0]), .i_key_next_addr_n(keys_n[1]), .i_key_ext_com_n(keys_n[2]),
      .i_sw(sw), .o_m_slave_sel(d1_slave_sel), .o_m_rw(d1_rw),
      .o_m_start_addr(d1_sa), .o_m_end_addr(d1_ea),
      .o_ext_wr_en(d1_wr_en), .o_ext_wr_addr(d1_wr_addr), .o_ext_wr_data(d1_wr_data),
      .o_cfg_start(d1_cfg_start), .i_cfg_done(cfg_done),
      .o_com_start(d1_com_start), .i_com_done(com_done),
      .o_rd_addr(d1_rd_addr), .o_ext_com_en(d1_ext_com), .o_com_ready(d1_ready),
      .o_com_all_done(d1_all_done), .o_state_code(d1_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: ext writes against the scoreboard, strobe counting and timing.
   always @(negedge clk) begin
      if (!rst) begin
         if (d0_wr_en != 2'b00) begin
            if (exp_q.size() == 0) chk("wr_unexpected", {2'b00, d0_wr_en, d0_wr_addr, d0_wr_data}, 32'h0);
            else chk("ext_wr", {2'b00, d0_wr_en, d0_wr_addr, d0_wr_data}, {2'b00, exp_q.pop_front()});
         end
         if (d0_cfg_start) cfg_cnt++;
         for (int b = 0; b < 2; b++) begin
            if (d0_com_start[b]) begin cs0_cyc[b] = cyc; cs0_cnt++; end
            if (d1_com_start[b]) begin cs1_cyc[b] = cyc; cs1_cnt++; end
         end
      end
   end

   task automatic clr_mon();
      cfg_cnt = 0; cs0_cnt = 0; cs1_cnt = 0;
      cs0_cyc[0] = -1; cs0_cyc[1] = -1; cs1_cyc[0] = -1; cs1_cyc[1] = -1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clr_mon();
   endtask

   task automatic press(input logic [2:0] mask, input int hold, input int settle);
      @(negedge clk);
      keys_n = ~mask;
      repeat (hold) @(negedge clk);
      keys_n = 3'b111;
      repeat (settle) @(negedge clk);
   endtask

   task automatic press_sw(input logic [17:0] v, input logic [2:0] mask);
      sw = v;
      press(mask, 1, 6);
   endtask

   task automatic wait_state(input string tag, input state_t s, input int max);
      int n = 0;
      while (d0_state !== s && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {28'h0, d0_state}, {28'h0, s});
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_state"}, {28'h0, d0_state}, {28'h0, ST_SLV_SEL});
      chk({pfx, "_sel_rw"}, {26'h0, d0_slave_sel, d0_rw}, 32'h0);
      chk({pfx, "_sa"}, {8'h0, d0_sa}, 32'h0);
      chk({pfx, "_ea"}, {8'h0, d0_ea}, 32'h0);
      chk({pfx, "_wr"}, {2'b00, d0_wr_en, d0_wr_addr, d0_wr_data}, 32'h0);
      chk({pfx, "_misc"}, {12'h0, d0_rd_addr, d0_cfg_start, d0_com_start, d0_ext_com, d0_ready, d0_all_done}, 32'h0);
      chk({pfx, "_d1_state"}, {28'h0, d1_state}, {28'h0, ST_SLV_SEL});
   endtask

   initial begin
      rst = 1'b1; keys_n = 3'b111; sw = '0; cfg_done = 1'b0; com_done = 2'b00;
      clr_mon();
      do_reset();
      chk_reset("rst0");

      // No slave selected: straight to DONE, no configuration.
      press_sw(18'h0, K_ST);
      wait_state("nosl_done", ST_DONE, 10);
      chk("nosl_all_done", {31'h0, d0_all_done}, 32'h1);
      chk("nosl_cfg_cnt", cfg_cnt, 0);
      press_sw(18'h9, K_NA);
      chk("rd_addr_9", {20'h0, d0_rd_addr}, 32'h9);
      press_sw(18'h3_005A, K_NA | K_EXT);
      chk("rd_addr_5a", {20'h0, d0_rd_addr}, 32'h5A);
      chk("ext_com_1", {31'h0, d0_ext_com}, 32'h1);
      press_sw(18'h0, K_EXT);
      chk("ext_com_0", {31'h0, d0_ext_com}, 32'h0);
      press(K_EXT, 100, 6);
      chk("ext_com_held", {31'h0, d0_ext_com}, 32'h1);

      // Full flow with external writes.
      do_reset();
      press_sw(18'h9, K_ST);
      wait_state("rw_sel", ST_RW_SEL, 10);
      chk("slave_sel", {28'h0, d0_slave_sel}, 32'h9);
      press_sw(18'h2, K_ST);
      chk("m_rw", {30'h0, d0_rw}, 32'h2);
      press_sw(18'h3, K_ST);
      wait_state("extw0", ST_EXTW0, 10);
      for (int i = 0; i < 3; i++) begin
         logic [15:0] d;
         d = 16'h1111 * 16'(i + 1);
         exp_q.push_back({2'b01, 12'(i), d});
         press_sw({2'b00, d}, K_NA);
      end
      exp_q.push_back({2'b01, 12'd3, 16'h4444});
      press_sw(18'h4444, K_ST);
      wait_state("extw1", ST_EXTW1, 10);
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back({2'b10, 12'((i < 15) ? i : 15), 16'(16'h0100 + i)});
         press_sw(18'(16'h0100 + i), K_NA);
      end
      exp_q.push_back({2'b10, 12'd15, 16'hBEEF});
      press_sw(18'hBEEF, K_ST | K_NA);
      wait_state("sa0", ST_SA0, 10);
      chk("wr_q_empty", exp_q.size(), 0);
      press_sw(18'h000, K_ST);
      press_sw(18'h001, K_ST);
      press_sw(18'h0AB, K_ST);
      press_sw(18'h3_0FFF, K_ST);
      wait_state("cfg", ST_CFG, 10);
      chk("start_addr", {8'h0, d0_sa}, 32'h001000);
      chk("end_addr", {8'h0, d0_ea}, 32'hFFF0AB);
      chk("cfg_cnt", cfg_cnt, 1);
      cfg_done = 1'b1;
      wait_state("ready", ST_READY, 10);
      chk("com_ready", {31'h0, d0_ready}, 32'h1);
      cfg_done = 1'b0;
      press_sw(18'h0, K_ST);
      repeat (6) @(negedge clk);
      wait_state("comm", ST_COMM, 10);
      chk("cs0_cnt", cs0_cnt, 2);
      chk("cs0_same_cycle", cs0_cyc[1] - cs0_cyc[0], 0);
      chk("cs1_cnt", cs1_cnt, 2);
      chk("cs1_delay", cs1_cyc[0] - cs1_cyc[1], 5);
      com_done = 2'b01;
      repeat (4) @(negedge clk);
      chk("comm_partial", {28'h0, d0_state}, {28'h0, ST_COMM});
      com_done = 2'b11;
      wait_state("all_done", ST_DONE, 10);
      chk("all_done_led", {31'h0, d0_all_done}, 32'h1);
      chk("d1_done", {28'h0, d1_state}, {28'h0, ST_DONE});
      com_done = 2'b00;

      // Reset while a delayed start is in flight.
      do_reset();
      press_sw(18'h1, K_ST);
      press_sw(18'h1, K_ST);
      press_sw(18'h0, K_ST);
      wait_state("skip_extw", ST_SA0, 10);
      for (int i = 0; i < 4; i++) press_sw(18'h0, K_ST);
      wait_state("cfg2", ST_CFG, 10);
      cfg_done = 1'b1;
      wait_state("ready2", ST_READY, 10);
      cfg_done = 1'b0;
      clr_mon();
      press(K_ST, 1, 0);
      wait_state("comm2", ST_COMM, 10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst_comm");
      repeat (10) @(negedge clk);
      chk("cs0_cnt_one", cs0_cnt, 1);
      chk("cs1_cancelled", cs1_cnt, 0);
      chk("wr_q_final", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_demo_ctrl.md
Name: bus_demo_ctrl

Overview:
- Operator-facing sequencing FSM of the two-master/three-slave serial-bus demo top level.
- Turns switch settings and push-button presses into per-master configuration:
  - slave choice, read/write, external memory writes, start/end addresses.
- Then launches bus communication, reports ready/done, and drives read-back and external-UART-link enable.
- Sits between the board I/O (SW, KEY, LEDG) and the master/slave/arbiter fabric.

Parameters:
- DATA_WIDTH, 16: master memory word width.
- ADDR_WIDTH, 12: master/slave address width (log2 of 4096).
- MAX_MASTER_WRITE_DEPTH, 16: max externally written addresses per master.
- FIRST_START_MASTER, 0: master started first (0 or 1).
- COM_START_DELAY, 0: cycles between the two masters' start pulses.

Ports:
- clk, in, 1: system clock (50 MHz).
- rst, in, 1: synchronous, active-high reset.
- key_state_n, in, 1: "next state" button, active-low.
- key_next_addr_n, in, 1: "next address" button, active-low.
- key_ext_com_n, in, 1: external-com toggle button, active-low.
- sw, in, 18: board switches.
- m_slave_sel, out, 2x2: per-master slave (0 none, 1..3 slave).
- m_rw, out, 2: per-master operation (1 write, 0 read).
- m_start_addr, out, 2xADDR_WIDTH: per-master slave start address.
- m_end_addr, out, 2xADDR_WIDTH: per-master slave end address.
- ext_wr_en, out, 2: one-cycle write strobe into master memory.
- ext_wr_addr, out, ADDR_WIDTH: write address.
- ext_wr_data, out, DATA_WIDTH: write data.
- cfg_start, out, 1: one-cycle pulse telling masters to load configuration.
- cfg_done, in, 1: all masters configured.
- com_start, out, 2: per-master start pulse.
- com_done, in, 2: per-master communication finished (level).
- rd_addr, out, ADDR_WIDTH: master memory read-back address.
- ext_com_en, out, 1: external UART link enabled.
- com_ready, out, 1: LEDG[1].
- com_all_done, out, 1: LEDG[2].
- state_code, out, 4: current state, for HEX display.

Behaviour:
- Button press:
  - Each key registered; press = 1->0 transition of the registered value.
  - Yields a one-cycle pulse; holding a key never repeats the pulse.
- Reset: state SLV_SEL; all outputs 0; write address counter 0.
- States and transitions (st = key_state press):
  - SLV_SEL:
    - On st: m_slave_sel[0]=sw[1:0], [1]=sw[3:2].
    - If both are 0 -> DONE, else -> RW_SEL.
  - RW_SEL: on st, m_rw={sw[1],sw[0]} -> EXTW_SEL.
  - EXTW_SEL: on st, latch ext-write enables sw[0] (m0), sw[1] (m1); counter=0 -> EXTW0.
  - EXTW0 and EXTW1 (each skipped when its enable is 0):
    - Next-address press: ext_wr_en[m]=1 with data sw[15:0] at counter; counter++.
    - Counter saturates at MAX_MASTER_WRITE_DEPTH-1; further presses overwrite the last address.
    - st: writes sw[15:0] at counter, resets counter to 0, advances.
  - SA0 -> SA1 -> EA0 -> EA1: on st latch sw[ADDR_WIDTH-1:0] into the matching address register.
  - EA1 -> CFG:
    - On entry pulse cfg_start.
    - Wait for cfg_done, then READY (com_ready=1).
  - READY -> COMM:
    - On st: com_start[FIRST_START_MASTER] pulses.
    - The other master pulses COM_START_DELAY cycles later (same cycle if 0).
    - Masters with no slave get no pulse and count as done.
  - COMM -> DONE: when every active master's com_done=1.
  - DONE:
    - com_all_done=1.
    - Next-address press latches sw[ADDR_WIDTH-1:0] into rd_addr.
    - Stays in DONE until rst.
- ext_com_en:
  - Toggles on each key_ext_com press, in any state.
  - A press in the same cycle as another press is handled independently.
- Simultaneous st and next-address press in EXTW states: st wins; the next-address press is ignored.
- rst mid-operation: immediate return to reset values; in-flight start delay cancelled.

Optional Feature:
- KEY_SYNC_EN defined:
  - Each key passes a 2-flop synchronizer before edge detection.
  - Press-to-action latency is 3 cycles.
- KEY_SYNC_EN undefined: single register; latency 1 cycle.

Decomposition:
- Package bus_demo_pkg:
  - slave_t enum (no_slave, slave_1..3).
  - master_t, operation_t.
  - state enum.
  - ADDR_WIDTH and DATA_WIDTH defaults.
- Sub-module key_press_det: synchronizer/edge detector, instantiated once per key.

Test Plan:
- sw[3:0]=0, st press -> DONE within 2 cycles after detection; com_all_done=1; no cfg_start.
- Full flow:
  - Slaves 1/2, rw=read/write, ext writes 1 each, addresses 0..1.
  - Expect cfg_start pulse; cfg_done -> com_ready=1.
  - st -> com_start[0] and [1] same cycle.
- Ext write:
  - Next-address ×3 with sw=0x1111/0x2222/0x3333, then st with 0x4444.
  - Expect writes to addr 0..3 in order.
  - 20 presses -> address saturates at 15.
- COM_START_DELAY=5, FIRST_START_MASTER=1 -> com_start[1] then com_start[0] exactly 5 cycles later.
- DONE, sw=9, next-address press -> rd_addr=9; two ext-com presses -> ext_com_en 0->1->0.
- Key held low 100 cycles -> exactly one action; rst asserted in COMM -> SLV_SEL, all outputs 0.
